// File: rtl/mult_sched_if.sv
// mult_sched_if: bundle of the requester, response and shared-multiplier
// signals of the mult_sched block.
//   slave  : view taken by mult_sched (accepts requests, drives multiplier
//            operands, returns responses).
//   master : view taken by the requesters / multiplier environment.
// Signals:
//   reqN_valid/ready/x/y  request handshake and operands, port N
//   rspN_valid/ready/data response handshake and result, port N
//   mul_x/mul_y           operands to the shared multiplier
//   mul_w                 product from the shared multiplier (low WIDTH bits)
//   busy                  scheduler not idle
interface mult_sched_if #(
    parameter int WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_x;
    logic [WIDTH-1:0] req0_y;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_x;
    logic [WIDTH-1:0] req1_y;
    logic [WIDTH-1:0] mul_x;
    logic [WIDTH-1:0] mul_y;
    logic [WIDTH-1:0] mul_w;
    logic             rsp0_valid;
    logic             rsp0_ready;
    logic [WIDTH-1:0] rsp0_data;
    logic             rsp1_valid;
    logic             rsp1_ready;
    logic [WIDTH-1:0] rsp1_data;
    logic             busy;

    modport slave (
        input  req0_valid, req0_x, req0_y,
        input  req1_valid, req1_x, req1_y,
        input  mul_w, rsp0_ready, rsp1_ready,
        output req0_ready, req1_ready,
        output mul_x, mul_y,
        output rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
        output busy
    );

    modport master (
        output req0_valid, req0_x, req0_y,
        output req1_valid, req1_x, req1_y,
        output mul_w, rsp0_ready, rsp1_ready,
        input  req0_ready, req1_ready,
        input  mul_x, mul_y,
        input  rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
        input  busy
    );
endinterface

// File: rtl/mult_sched.sv
// mult_sched: two-port round-robin scheduler in front of a single shared
// multiplier. One operation in flight; operands are held on mul_x/mul_y for
// LATENCY cycles, then mul_w is captured and returned to the owning port.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    mult_sched_if.slave (request, response and multiplier signals)
module mult_sched #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 3
) (
    input logic        clk,
    input logic        rst_n,
    mult_sched_if.slave bus
);
    // Counter only ever holds LATENCY-1 .. 0.
    localparam int              CW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0]   CNT_INIT = CW'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, state_next;
    logic [CW-1:0]    cnt;
    logic             owner;
    logic             last_grant;
    logic             grant;
    logic             accept;
    logic [1:0]       req_valid;
    logic [1:0]       rsp_ready;
    logic [WIDTH-1:0] op_x, op_y, result;

    assign req_valid = {bus.req1_valid, bus.req0_valid};
    assign rsp_ready = {bus.rsp1_ready, bus.rsp0_ready};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        // Contention goes to the port that did not win last time.
        case (req_valid)
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last_grant;
            default: grant = 1'b0;
        endcase
        case (state)
            IDLE: if (|req_valid) begin
                accept     = 1'b1;
                state_next = BUSY;
            end
            BUSY: if (cnt == '0) state_next = DONE;
            DONE: if (rsp_ready[owner]) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            owner      <= 1'b0;
            last_grant <= 1'b1;   // port 0 wins the first contention
            op_x       <= '0;
            op_y       <= '0;
            result     <= '0;
        end else if (accept) begin
            op_x       <= grant ? bus.req1_x : bus.req0_x;
            op_y       <= grant ? bus.req1_y : bus.req0_y;
            owner      <= grant;
            last_grant <= grant;
            cnt        <= CNT_INIT;
        end else if (state == BUSY) begin
            if (cnt != '0) cnt    <= cnt - 1'b1;
            else           result <= bus.mul_w;
        end
    end

    assign bus.req0_ready = accept & ~grant;
    assign bus.req1_ready = accept &  grant;
    assign bus.mul_x      = op_x;
    assign bus.mul_y      = op_y;
    assign bus.rsp0_valid = (state == DONE) & ~owner;
    assign bus.rsp1_valid = (state == DONE) &  owner;
    // Data is shared; only the valid tells which port it belongs to.
    assign bus.rsp0_data  = result;
    assign bus.rsp1_data  = result;
    assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_mult_sched.sv
// tb_mult_sched: directed bench for mult_sched (WIDTH=32, LATENCY=3).
// The shared multiplier is a plain combinational product of mul_x*mul_y.
module tb_mult_sched;
    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    mult_sched_if #(.WIDTH(32)) bus ();

    mult_sched #(.WIDTH(32), .LATENCY(3)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    assign bus.mul_w = bus.mul_x * bus.mul_y;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete operation on a port, response consumed immediately.
    task automatic do_op(input int port, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] exp, input string tag);
        int n;
        if (port == 0) begin
            bus.rsp0_ready = 1'b1; bus.req0_x = x; bus.req0_y = y; bus.req0_valid = 1'b1;
        end else begin
            bus.rsp1_ready = 1'b1; bus.req1_x = x; bus.req1_y = y; bus.req1_valid = 1'b1;
        end
        #1;
        n = 0;
        while (((port == 0) ? bus.req0_ready : bus.req1_ready) !== 1'b1 && n < 20) begin
            tick(); n++;
        end
        chk({tag, "_ready"}, (port == 0) ? bus.req0_ready : bus.req1_ready, 1);
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        #1;
        n = 0;
        while (((port == 0) ? bus.rsp0_valid : bus.rsp1_valid) !== 1'b1 && n < 20) begin
            tick(); n++;
        end
        chk({tag, "_rvalid"}, (port == 0) ? bus.rsp0_valid : bus.rsp1_valid, 1);
        chk({tag, "_data"}, (port == 0) ? bus.rsp0_data : bus.rsp1_data, exp);
        tick();
        chk({tag, "_idle"}, bus.busy, 0);
    endtask

    initial begin
        int n;
        int seen;
        logic [31:0] cap;
        int ord[6];
        int at[6];
        int nacc;
        int both;

        // ---- reset state ----
        rst_n = 1'b0;
        bus.req0_valid = 0; bus.req0_x = 0; bus.req0_y = 0;
        bus.req1_valid = 0; bus.req1_x = 0; bus.req1_y = 0;
        bus.rsp0_ready = 0; bus.rsp1_ready = 0;
        #22;
        chk("rst_busy", bus.busy, 0);
        chk("rst_req0_ready", bus.req0_ready, 0);
        chk("rst_rsp0_valid", bus.rsp0_valid, 0);
        chk("rst_rsp1_valid", bus.rsp1_valid, 0);
        chk("rst_rsp_data", bus.rsp0_data, 0);
        chk("rst_mul_x", bus.mul_x, 0);
        rst_n = 1'b1;
        tick();

        // ---- single op, latency profile ----
        bus.rsp0_ready = 1'b1;
        bus.req0_x = 7; bus.req0_y = 6; bus.req0_valid = 1'b1;
        #1;
        chk("s_req0_ready", bus.req0_ready, 1);
        chk("s_req1_ready", bus.req1_ready, 0);
        tick();                                  // E0
        bus.req0_valid = 1'b0;
        #1;
        chk("s_mul_x", bus.mul_x, 7);
        chk("s_mul_y", bus.mul_y, 6);
        chk("s_busy", bus.busy, 1);
        chk("s_req0_ready_busy", bus.req0_ready, 0);
        chk("s_rv_e1", bus.rsp0_valid, 0);
        tick();                                  // after E0+1
        chk("s_rv_e2", bus.rsp0_valid, 0);
        tick();                                  // after E0+2
        chk("s_rv_e3", bus.rsp0_valid, 0);
        tick();                                  // after E0+3
        chk("s_rv", bus.rsp0_valid, 1);
        chk("s_data", bus.rsp0_data, 42);
        chk("s_rsp1_valid", bus.rsp1_valid, 0);
        tick();                                  // after E0+4
        chk("s_done_idle", bus.busy, 0);
        chk("s_rv_off", bus.rsp0_valid, 0);
        chk("s_mul_x_hold", bus.mul_x, 7);

        // ---- wrap / truncation ----
        do_op(0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, "wrap_a");
        do_op(1, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, "wrap_b");
        do_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, "wrap_c");

        // ---- backpressure on port 1 ----
        bus.rsp1_ready = 1'b0;
        bus.req1_x = 32'h1234; bus.req1_y = 1; bus.req1_valid = 1'b1;
        #1;
        chk("bp_req1_ready", bus.req1_ready, 1);
        tick();
        bus.req1_valid = 1'b0;
        bus.req0_x = 3; bus.req0_y = 5; bus.req0_valid = 1'b1; bus.rsp0_ready = 1'b0;
        #1;
        n = 0;
        while (bus.rsp1_valid !== 1'b1 && n < 20) begin tick(); n++; end
        chk("bp_wait", bus.rsp1_valid, 1);
        for (int i = 0; i < 8; i++) begin
            chk("bp_rv", bus.rsp1_valid, 1);
            chk("bp_data", bus.rsp1_data, 32'h1234);
            chk("bp_busy", bus.busy, 1);
            chk("bp_req0_ready", bus.req0_ready, 0);
            tick();
        end
        bus.rsp1_ready = 1'b1;
        tick();                                  // DONE -> IDLE
        chk("bp_idle", bus.busy, 0);
        chk("bp_rv_off", bus.rsp1_valid, 0);
        chk("bp_req0_ready_idle", bus.req0_ready, 1);
        bus.rsp1_ready = 1'b0;
        tick();                                  // req0 accepted
        bus.req0_valid = 1'b0;
        bus.rsp0_ready = 1'b1;
        #1;
        chk("bp_next_mul_x", bus.mul_x, 3);
        chk("bp_next_busy", bus.busy, 1);
        n = 0;
        while (bus.rsp0_valid !== 1'b1 && n < 20) begin tick(); n++; end
        chk("bp_next_rv", bus.rsp0_valid, 1);
        chk("bp_next_data", bus.rsp0_data, 15);
        tick();

        // ---- withdrawal of req1 while busy ----
        bus.rsp0_ready = 1'b1;
        bus.req0_x = 2; bus.req0_y = 3; bus.req0_valid = 1'b1;
        #1;
        chk("wd_req0_ready", bus.req0_ready, 1);
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_x = 9; bus.req1_y = 9; bus.req1_valid = 1'b1;
        #1;
        chk("wd_req1_ready", bus.req1_ready, 0);
        tick();
        bus.req1_valid = 1'b0;
        seen = 0;
        cap = 32'hDEAD_BEEF;
        for (int i = 0; i < 10; i++) begin
            if (bus.rsp1_valid === 1'b1 || bus.req1_ready === 1'b1) seen++;
            if (bus.rsp0_valid === 1'b1) cap = bus.rsp0_data;
            tick();
        end
        chk("wd_no_rsp1", seen, 0);
        chk("wd_rsp0_data", cap, 6);

        // ---- reset mid-BUSY ----
        bus.rsp1_ready = 1'b1;
        bus.req1_x = 5; bus.req1_y = 5; bus.req1_valid = 1'b1;
        #1;
        tick();
        bus.req1_valid = 1'b0;
        tick();
        chk("mr_busy_before", bus.busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_busy", bus.busy, 0);
        chk("mr_mul_x", bus.mul_x, 0);
        chk("mr_mul_y", bus.mul_y, 0);
        chk("mr_rsp1_valid", bus.rsp1_valid, 0);
        chk("mr_rsp1_data", bus.rsp1_data, 0);
        tick();
        rst_n = 1'b1;
        tick();
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.rsp1_valid === 1'b1) seen++;
            tick();
        end
        chk("mr_dropped", seen, 0);
        do_op(0, 7, 6, 42, "mr_after");

        // ---- contention, round robin from a fresh reset ----
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();
        bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
        bus.req0_x = 10; bus.req0_y = 10; bus.req0_valid = 1'b1;
        bus.req1_x = 20; bus.req1_y = 20; bus.req1_valid = 1'b1;
        #1;
        nacc = 0;
        both = 0;
        for (int c = 0; c < 60 && nacc < 6; c++) begin
            if (bus.req0_ready === 1'b1 && bus.req1_ready === 1'b1) both++;
            if (bus.req0_ready === 1'b1) begin ord[nacc] = 0; at[nacc] = c; nacc++; end
            else if (bus.req1_ready === 1'b1) begin ord[nacc] = 1; at[nacc] = c; nacc++; end
            tick();
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        chk("rr_count", nacc, 6);
        chk("rr_both_ready", both, 0);
        if (nacc == 6) begin
            for (int i = 0; i < 6; i++) chk($sformatf("rr_order%0d", i), ord[i], i % 2);
            for (int i = 1; i < 6; i++) chk($sformatf("rr_gap%0d", i), at[i] - at[i-1], 5);
        end
        n = 0;
        while (bus.busy !== 1'b0 && n < 20) begin tick(); n++; end
        chk("rr_drain", bus.busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
